mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM (`memory` instance: registered address/data/wren, 1-cycle read latency on q) between two requesters: the CPU instruction-fetch port (I) and the CPU load/store port (D).
- Sits between `cpu` and the unified program/data memory in `top_level`, replacing the separate INSTRUCTION_MEMORY/DATA_MEMORY pair.
- Arbitration: data priority with a starvation guard, a read-return pipeline, and the return data routed to the requester that issued the read.

Parameters:
- ADDR_W, 8, word address width of the shared memory
- DATA_W, 32, data word width
- STARVE_MAX, 4, max consecutive D grants while I is waiting before I is forced through (legal range 1..15)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (load only, cycle after d_gnt)
- d_rdata  out  DATA_W  load data
- mem_address  out  ADDR_W  to memory.address
- mem_data  out  DATA_W  to memory.data
- mem_wren  out  1  to memory.wren
- mem_q  in  DATA_W  from memory.q

Behaviour:
- At most one grant per cycle. i_gnt and d_gnt are never both 1.
- The grant is a combinational function of i_req, d_req and the registered priority state. The memory address/data/wren mux follows the grant. With no grant: mem_wren = 0, mem_address = i_addr, mem_data = d_wdata.
- Priority state machine, two states:
  - PRI_D (reset state): d_req wins; I is granted only if d_req = 0.
  - PRI_I: i_req wins; D is granted only if i_req = 0.
- Starvation counter (4 bits, reset 0):
  - Increments on each cycle with d_gnt = 1 and i_req = 1.
  - Clears on i_gnt or when i_req = 0.
  - When it reaches STARVE_MAX, the next state is PRI_I.
  - PRI_I returns to PRI_D after the first i_gnt. If i_req drops while in PRI_I, return to PRI_D and clear the counter.
- Read return:
  - Registered owner tag, reset OWN_NONE: set to OWN_I on i_gnt, OWN_D on d_gnt with d_we = 0, otherwise OWN_NONE.
  - i_rvalid = (owner == OWN_I); d_rvalid = (owner == OWN_D).
  - i_rdata and d_rdata are both driven from mem_q. Latency is exactly 1 cycle after the grant.
- Stores: d_gnt is the completion. No rvalid is produced. A store and the following fetch to the same address in back-to-back cycles return the new data (memory is configured for new-data read-during-write across cycles).
- Back-to-back: a grant every cycle is legal. An rvalid for the previous grant coexists with the current grant.
- Reset mid-operation: the owner tag clears, so a pending rvalid is dropped. State goes to PRI_D, the counter clears, and all outputs drive 0 except the address/data mux defaults.
- Requester dropping req before its grant: the request is treated as withdrawn, with no side effects.

Optional Feature:
- Macro MEM_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_i_grants[31:0], stat_d_grants[31:0], stat_i_stalls[31:0] (cycles with i_req = 1 and i_gnt = 0) and input stat_clr.
  - Counters saturate at all-ones.
  - Counters are cleared by rst or stat_clr. stat_clr has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_I, OWN_D}
  - pri_e enum {PRI_D, PRI_I}
  - STAT_W = 32
- Sub-module mem_arb_stats: the three saturating counters, instantiated only under MEM_ARBITER_STATS_EN.

Test Plan:
- Reset held 3 cycles with i_req = d_req = 1 → all gnt/rvalid = 0 and mem_wren = 0. After release, first grant is d_gnt (PRI_D).
- i_req only, i_addr 0x10 then 0x11 on consecutive cycles, memory preloaded 0x10 = 0xDEADBEEF, 0x11 = 0x00000013 → i_gnt both cycles. i_rvalid in the following two cycles with i_rdata 0xDEADBEEF then 0x00000013. d_rvalid stays 0.
- d_req store to 0x20 of 0xCAFEF00D, then fetch 0x20 → d_gnt with mem_wren = 1 and no d_rvalid. Next cycle i_gnt. One cycle later i_rvalid with i_rdata 0xCAFEF00D.
- i_req and d_req (loads) both held continuously, STARVE_MAX = 4 → grant pattern D,D,D,D,I repeating. Never more than 4 consecutive d_gnt while i_req = 1.
- Assert rst in the cycle after a d_gnt load → d_rvalid is not asserted in the following cycle. Owner returns to OWN_NONE.
- With MEM_ARBITER_STATS_EN: the starvation scenario for 10 cycles → stat_d_grants = 8, stat_i_grants = 2, stat_i_stalls = 8. stat_clr pulse → all 0 next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Who is waiting for read data in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Which requester currently wins a simultaneous request.
  typedef enum logic {
    PRI_D = 1'b0,
    PRI_I = 1'b1
  } pri_e;

  localparam int STAT_W = 32;
  localparam int CNT_W  = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v == {STAT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating grant/stall counters for the memory arbiter.
// Instantiated only when MEM_ARBITER_STATS_EN is defined.
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_clr,
  input  logic              i_req,
  input  logic              i_gnt,
  input  logic              d_gnt,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_i_stalls
);

  logic stall_s;

  assign stall_s = i_req & ~i_gnt;

  // Count grants and fetch stalls; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_i_grants <= {STAT_W{1'b0}};
      stat_d_grants <= {STAT_W{1'b0}};
      stat_i_stalls <= {STAT_W{1'b0}};
    end else begin
      stat_i_grants <= i_gnt   ? sat_inc(stat_i_grants) : stat_i_grants;
      stat_d_grants <= d_gnt   ? sat_inc(stat_d_grants) : stat_d_grants;
      stat_i_stalls <= stall_s ? sat_inc(stat_i_stalls) : stat_i_stalls;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the CPU fetch
// port (I) and load/store port (D). Data has priority, with a starvation
// guard that forces a waiting fetch through after STARVE_MAX data grants.
// Read data returns one cycle after the grant, tagged to its requester.
// Optional statistics counters: define MEM_ARBITER_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef MEM_ARBITER_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_i_stalls
`endif
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  pri_e             pri_r, pri_next_s;
  owner_e           owner_r, owner_next_s;
  logic [CNT_W-1:0] starve_cnt_r, starve_cnt_next_s;
  logic             i_gnt_s, d_gnt_s;

  // Grant decision from requests and the current priority; nothing during reset.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else begin
      case (pri_r)
        PRI_D: begin
          d_gnt_s = d_req;
          i_gnt_s = i_req & ~d_req;
        end
        PRI_I: begin
          i_gnt_s = i_req;
          d_gnt_s = d_req & ~i_req;
        end
        default: begin
          d_gnt_s = d_req;
          i_gnt_s = i_req & ~d_req;
        end
      endcase
    end
  end

  // Steer the memory port to the granted requester; idle defaults to a fetch address.
  always_comb begin
    mem_address = i_addr;
    mem_data    = d_wdata;
    mem_wren    = 1'b0;
    if (d_gnt_s) begin
      mem_address = d_addr;
      mem_wren    = d_we;
    end else begin
      mem_address = i_addr;
      mem_wren    = 1'b0;
    end
  end

  // Count data grants that pass over a waiting fetch and pick the next priority.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    pri_next_s        = pri_r;
    if (!i_req || i_gnt_s) begin
      starve_cnt_next_s = {CNT_W{1'b0}};
    end else if (d_gnt_s) begin
      starve_cnt_next_s = (starve_cnt_r == CNT_SAT) ? CNT_SAT
                        : starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
    case (pri_r)
      PRI_D: begin
        if (starve_cnt_next_s >= STARVE_LIM) begin
          pri_next_s = PRI_I;
        end else begin
          pri_next_s = PRI_D;
        end
      end
      PRI_I: begin
        if (i_gnt_s || !i_req) begin
          pri_next_s = PRI_D;
        end else begin
          pri_next_s = PRI_I;
        end
      end
      default: pri_next_s = PRI_D;
    endcase
  end

  // Remember which requester owns the read data returning next cycle.
  always_comb begin
    owner_next_s = OWN_NONE;
    if (i_gnt_s) begin
      owner_next_s = OWN_I;
    end else if (d_gnt_s && !d_we) begin
      owner_next_s = OWN_D;
    end else begin
      owner_next_s = OWN_NONE;
    end
  end

  // Priority, starvation counter and owner tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_r        <= PRI_D;
      starve_cnt_r <= {CNT_W{1'b0}};
      owner_r      <= OWN_NONE;
    end else begin
      pri_r        <= pri_next_s;
      starve_cnt_r <= starve_cnt_next_s;
      owner_r      <= owner_next_s;
    end
  end

  assign i_gnt    = i_gnt_s;
  assign d_gnt    = d_gnt_s;
  // A return due during reset is dropped, not delivered.
  assign i_rvalid = (owner_r == OWN_I) & ~rst;
  assign d_rvalid = (owner_r == OWN_D) & ~rst;
  assign i_rdata  = mem_q;
  assign d_rdata  = mem_q;

`ifdef MEM_ARBITER_STATS_EN
  mem_arb_stats u_stats (
    .clk           (clk),
    .rst           (rst),
    .stat_clr      (stat_clr),
    .i_req         (i_req),
    .i_gnt         (i_gnt_s),
    .d_gnt         (d_gnt_s),
    .stat_i_grants (stat_i_grants),
    .stat_d_grants (stat_d_grants),
    .stat_i_stalls (stat_i_stalls)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a RAM model behind the arbiter, a
// request-level reference model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
`ifdef MEM_ARBITER_STATS_EN
  logic              stat_clr;
  logic [31:0]       stat_i_grants;
  logic [31:0]       stat_d_grants;
  logic [31:0]       stat_i_stalls;
`endif

  logic ram_init;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_i_grants (stat_i_grants),
    .stat_d_grants (stat_d_grants),
    .stat_i_stalls (stat_i_stalls)
`endif
  );

  // Single-port synchronous RAM: registered write, 1-cycle registered read.
  logic [DATA_W-1:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= 32'h0;
      ram[8'h10] <= 32'hDEADBEEF;
      ram[8'h11] <= 32'h00000013;
    end else if (mem_wren) begin
      ram[mem_address] <= mem_data;
    end
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, fetch-starvation streak, pending return.
  logic [DATA_W-1:0] shadow [0:255];
  bit                exp_rv_i = 1'b0;
  bit                exp_rv_d = 1'b0;
  logic [DATA_W-1:0] exp_rdata = 32'h0;
  int                streak = 0;

  always @(negedge clk) begin
    bit exp_i;
    bit exp_d;
    if (ram_init) begin
      for (int k = 0; k < 256; k++) shadow[k] = 32'h0;
      shadow[8'h10] = 32'hDEADBEEF;
      shadow[8'h11] = 32'h00000013;
    end
    // returns from last cycle's grant
    chk("i_rvalid", 32'(i_rvalid), 32'(exp_rv_i & ~rst));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_rv_d & ~rst));
    if (exp_rv_i && !rst) chk("i_rdata", i_rdata, exp_rdata);
    if (exp_rv_d && !rst) chk("d_rdata", d_rdata, exp_rdata);
    // this cycle's grant: data first, unless the fetch has waited STARVE_MAX data grants
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (!rst) begin
      if (i_req && (!d_req || streak >= STARVE_MAX)) exp_i = 1'b1;
      else if (d_req) exp_d = 1'b1;
    end
    chk("i_gnt", 32'(i_gnt), 32'(exp_i));
    chk("d_gnt", 32'(d_gnt), 32'(exp_d));
    chk("mem_wren", 32'(mem_wren), 32'(exp_d & d_we));
    chk("mem_address", 32'(mem_address), 32'(exp_d ? d_addr : i_addr));
    chk("mem_data", mem_data, d_wdata);
    // advance model
    exp_rv_i  = exp_i;
    exp_rv_d  = exp_d & ~d_we;
    exp_rdata = shadow[exp_i ? i_addr : d_addr];
    if (exp_d && d_we) shadow[d_addr] = d_wdata;
    if (rst || !i_req || exp_i) streak = 0;
    else if (exp_d) streak = streak + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [31:0] dd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  initial begin
    rst      = 1'b1;
    ram_init = 1'b1;
`ifdef MEM_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h11, 32'h0);

    // reset held 3 cycles with both requesting
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_i_gnt", 32'(i_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      tick();
    end
    rst      = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);
    chk("first_gnt_d", 32'({i_gnt, d_gnt}), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();

    // back-to-back fetches
    drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk); chk("fetch0_gnt", 32'(i_gnt), 32'd1);
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk); chk("fetch1_gnt", 32'(i_gnt), 32'd1);
    chk("fetch0_rv", 32'(i_rvalid), 32'd1);
    chk("fetch0_data", i_rdata, 32'hDEADBEEF);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("fetch1_rv", 32'(i_rvalid), 32'd1);
    chk("fetch1_data", i_rdata, 32'h00000013);
    chk("fetch_no_drv", 32'(d_rvalid), 32'd0);
    tick();

    // store then fetch of the same address
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
    @(negedge clk);
    chk("store_gnt", 32'({d_gnt, mem_wren}), 32'd3);
    tick();
    drive(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("store_i_gnt", 32'(i_gnt), 32'd1);
    chk("store_no_drv", 32'(d_rvalid), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("raw_rv", 32'(i_rvalid), 32'd1);
    chk("raw_data", i_rdata, 32'hCAFEF00D);
`ifdef MEM_ARBITER_STATS_EN
    stat_clr = 1'b1;
`endif
    tick();
`ifdef MEM_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif

    // starvation: both held, loads; expect D,D,D,D,I twice
    drive(1'b1, 8'h11, 1'b1, 1'b0, 8'h10, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("starve_i", 32'(i_gnt), 32'((k == 4) || (k == 9)));
      chk("starve_d", 32'(d_gnt), 32'((k != 4) && (k != 9)));
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
`ifdef MEM_ARBITER_STATS_EN
    @(negedge clk);
    chk("stat_d_grants", stat_d_grants, 32'd8);
    chk("stat_i_grants", stat_i_grants, 32'd2);
    chk("stat_i_stalls", stat_i_stalls, 32'd8);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr", stat_d_grants | stat_i_grants | stat_i_stalls, 32'd0);
`endif
    tick();

    // reset right after a load grant drops its return
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clk); chk("mid_load_gnt", 32'(d_gnt), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk); chk("mid_rst_drv", 32'(d_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk); chk("post_rst_drv", 32'(d_rvalid), 32'd0);
    tick();

    // mixed directed vectors, checked by the model
    drive(1'b1, 8'h20, 1'b1, 1'b1, 8'h40, 32'h11111111); tick();
    drive(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 32'h0);        tick();
    drive(1'b1, 8'h40, 1'b1, 1'b0, 8'h20, 32'h0);        tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 32'h22222222); tick();
    drive(1'b1, 8'h41, 1'b1, 1'b0, 8'h10, 32'h0);        tick();
    drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 32'h0);        tick();
    // streak reaches the limit, then the fetch withdraws
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'h11, 1'b1, 1'b0, 8'h40, 32'h0); tick();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 32'h33333333); tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'h42, 1'b1, 1'b0, 8'h41, 32'h0); tick();
    end
    drive(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 32'h0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0); tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
